// File: rtl/element_multiplication_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : element_multiplication_sequencer
// Description : Drives one element-wise bind. Reads A[idx] and B[idx] from a
//               single-port 1-cycle-latency memory, hands each pair to the FP
//               multiplication unit with valid/first/last, and writes every
//               product to the result memory before moving to the next index.
// Revision    : 1.0 - initial release
// ============================================================================
module element_multiplication_sequencer #(
  parameter int HV_DATA_WIDTH = 32,
  parameter int HV_DIM        = 1024,
  parameter int ADDR_WIDTH    = 10
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic [ADDR_WIDTH-1:0]    a_base,
  input  logic [ADDR_WIDTH-1:0]    b_base,
  input  logic [ADDR_WIDTH-1:0]    r_base,
  output logic                     mem_rd_en,
  output logic [ADDR_WIDTH-1:0]    mem_rd_addr,
  input  logic [HV_DATA_WIDTH-1:0] mem_rd_data,
  output logic                     res_wr_en,
  output logic [ADDR_WIDTH-1:0]    res_wr_addr,
  output logic [HV_DATA_WIDTH-1:0] res_wr_data,
  output logic                     bind_valid,
  output logic                     bind_first,
  output logic                     bind_last,
  output logic [HV_DATA_WIDTH-1:0] bind_data,
  input  logic [HV_DATA_WIDTH-1:0] bind_data_out,
  input  logic                     bind_ready,
  input  logic                     bind_done,
  output logic                     busy,
  output logic                     done
);

  localparam int IDX_W = (HV_DIM > 1) ? $clog2(HV_DIM) : 1;
  localparam logic [IDX_W-1:0] C_IDX_LAST = IDX_W'(HV_DIM - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_UNIT = 3'd1,
    S_RD_A      = 3'd2,
    S_RD_B      = 3'd3,
    S_LAST      = 3'd4,
    S_WAIT_RES  = 3'd5,
    S_DONE      = 3'd6
  } state_t;

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [ADDR_WIDTH-1:0] a_base_q, a_base_d;
  logic [ADDR_WIDTH-1:0] b_base_q, b_base_d;
  logic [ADDR_WIDTH-1:0] r_base_q, r_base_d;
  logic [ADDR_WIDTH-1:0] idx_addr;

  // Element index widened/truncated to address width; base+idx wraps silently.
  assign idx_addr = ADDR_WIDTH'(idx_q);

  // State, index and latched bases; synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      a_base_q <= '0;
      b_base_q <= '0;
      r_base_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      a_base_q <= a_base_d;
      b_base_q <= b_base_d;
      r_base_q <= r_base_d;
    end
  end

  // Next-state logic and state-decoded outputs (no output register stage).
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    a_base_d    = a_base_q;
    b_base_d    = b_base_q;
    r_base_d    = r_base_q;
    mem_rd_en   = 1'b0;
    mem_rd_addr = '0;
    res_wr_en   = 1'b0;
    res_wr_addr = '0;
    res_wr_data = '0;
    bind_valid  = 1'b0;
    bind_first  = 1'b0;
    bind_last   = 1'b0;
    bind_data   = '0;
    busy        = (state_q != S_IDLE);
    done        = 1'b0;

    case (state_q)
      S_IDLE: begin
        // start is only honoured here, so a pulse while busy is harmless.
        if (start) begin
          a_base_d = a_base;
          b_base_d = b_base;
          r_base_d = r_base;
          idx_d    = '0;
          state_d  = S_WAIT_UNIT;
        end
      end
      S_WAIT_UNIT: begin
        // Also absorbs the unit coming out of a shared reset a cycle late.
        if (bind_ready && bind_done) state_d = S_RD_A;
      end
      S_RD_A: begin
        mem_rd_en   = 1'b1;
        mem_rd_addr = a_base_q + idx_addr;
        state_d     = S_RD_B;
      end
      S_RD_B: begin
        // A[idx] returns now while B[idx] is being requested.
        mem_rd_en   = 1'b1;
        mem_rd_addr = b_base_q + idx_addr;
        bind_valid  = 1'b1;
        bind_first  = 1'b1;
        bind_data   = mem_rd_data;
        state_d     = S_LAST;
      end
      S_LAST: begin
        bind_valid = 1'b1;
        bind_last  = 1'b1;
        bind_data  = mem_rd_data;
        state_d    = S_WAIT_RES;
      end
      S_WAIT_RES: begin
        // The unit cleared bind_done when it took 'first', so level is enough.
        if (bind_done) begin
          res_wr_en   = 1'b1;
          res_wr_addr = r_base_q + idx_addr;
          res_wr_data = bind_data_out;
          if (idx_q == C_IDX_LAST) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_WAIT_UNIT;
          end
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: doc/element_multiplication_sequencer.md
# element_multiplication_sequencer

Initiator side of the element-wise binding stream. On `start`, it reads hypervectors A and B from a single-port, 1-cycle-latency memory one element at a time. It drives each A/B pair into the floating-point element-multiplication unit with the valid/first/last handshake, waits for that unit's ready/done, and writes each product to the result memory. It sits between the HV memory and the binding datapath and owns element sequencing for one bind operation.

## Interface
- `HV_DATA_WIDTH`, 32, element width (FP32)
- `HV_DIM`, 1024, elements per hypervector (≥1)
- `ADDR_WIDTH`, 10, memory address width
- `clk` in 1: the block's only clock.
- `reset_n` in 1: synchronous, active-low reset.
- `start` in 1: one-cycle request; sampled only in S_IDLE.
- `a_base`, `b_base`, `r_base` in ADDR_WIDTH: base addresses of A, B and the result; latched on accepted `start`.
- `mem_rd_en` out 1: read strobe; data returns on `mem_rd_data` the next cycle.
- `mem_rd_addr` out ADDR_WIDTH: read address.
- `mem_rd_data` in HV_DATA_WIDTH: read data.
- `res_wr_en` out 1: result write strobe.
- `res_wr_addr` out ADDR_WIDTH: result write address.
- `res_wr_data` out HV_DATA_WIDTH: result write data.
- `bind_valid`, `bind_first`, `bind_last` out 1: handshake to the multiplication unit.
- `bind_data` out HV_DATA_WIDTH: operand to the unit.
- `bind_data_out` in HV_DATA_WIDTH: product from the unit.
- `bind_ready`, `bind_done` in 1: unit status.
- `busy` out 1: high in every state except S_IDLE.
- `done` out 1: one-cycle pulse when all HV_DIM results are written.

## Operation
- Element index `idx` counts 0..HV_DIM-1. Addresses are `base+idx`, truncated mod 2^ADDR_WIDTH; wrap-around is legal and silent.
- States and outputs. All outputs not listed are 0.
  - S_IDLE: if `start`, latch the bases, set `idx`=0, go to S_WAIT_UNIT. Otherwise stay.
  - S_WAIT_UNIT: if `bind_ready & bind_done`, go to S_RD_A. Otherwise stay, with no timeout.
  - S_RD_A: `mem_rd_en`=1, `mem_rd_addr`=a_base+idx. Go to S_RD_B.
  - S_RD_B: `mem_rd_en`=1, `mem_rd_addr`=b_base+idx. Also `bind_valid`=`bind_first`=1 and `bind_data`=`mem_rd_data` (A[idx]). Go to S_LAST.
  - S_LAST: `bind_valid`=`bind_last`=1, `bind_data`=`mem_rd_data` (B[idx]). Go to S_WAIT_RES.
  - S_WAIT_RES: while `bind_done`=0, stay. When `bind_done`=1:
    - in the same cycle, drive `res_wr_en`=1, `res_wr_addr`=r_base+idx, `res_wr_data`=`bind_data_out`;
    - if idx==HV_DIM-1, go to S_DONE; else increment idx and go to S_WAIT_UNIT.
  - S_DONE: `done`=1 for this one cycle. Go to S_IDLE.
- `bind_done` is already low on entry to S_WAIT_RES, because the unit clears it on accepting `first`. No edge detection is required.
- `start` while `busy` is ignored and has no effect on the running operation.
- `bind_first` and `bind_last` are never high in the same cycle. `bind_valid` is never high outside S_RD_B and S_LAST.

## Timing
- Reset (`reset_n`=0 at a clk edge):
  - state goes to S_IDLE; idx and the latched bases go to 0;
  - every output reads 0 the following cycle.
- Reset mid-operation abandons the vector. No partial `done`; writes already issued stand.
- Outputs decode from state, plus pass-through of `mem_rd_data`/`bind_data_out`. No extra register stage.
- Per-element cost with the current unit (3-cycle multiply, ready/done back 4 edges after `last`):
  - 1 cycle each in S_WAIT_UNIT, S_RD_A, S_RD_B, S_LAST;
  - 4 cycles in S_WAIT_RES;
  - 8 cycles per element in total.
- Total latency from `start` to `done`: 1 + 8·HV_DIM + 1 cycles.
- Following a reset shared with the unit, `bind_ready`/`bind_done` rise one cycle late. S_WAIT_UNIT absorbs this.

## Test plan
- HV_DIM=4, A={1.0,2.0,3.0,4.0}, B={2.0,0.5,-1.0,0.0}, bases 0/16/32, unit model at nominal latency:
  - R[32..35] = {2.0,1.0,-3.0,0.0};
  - `done` pulses exactly at cycle 34 after `start`.
- Protocol check over a full run:
  - `bind_first` is asserted exactly 1 cycle before each `bind_last`, with A then B data;
  - `mem_rd_en` is high for exactly 2 cycles per element;
  - `res_wr_en` fires exactly HV_DIM times.
- `a_base`=1022, HV_DIM=4, ADDR_WIDTH=10 -> A reads hit addresses 1022, 1023, 0, 1.
- Unit model stalls `bind_done` for 20 extra cycles on element 2:
  - the FSM holds in S_WAIT_RES;
  - no write occurs until `bind_done`=1;
  - result values are unchanged.
- `start` pulsed again mid-run -> ignored; bases, idx and result writes are unaffected.
- `reset_n` low during S_WAIT_RES of element 1:
  - all outputs 0 the next cycle, `busy`=0;
  - a fresh `start` completes correctly.
